// File: rtl/bt656_sync_decoder_if.sv
// Signal bundle between the BT.656 byte source and the sync decoder.
// The source drives d; the decoder drives every other signal.
`timescale 1ns/1ps
interface bt656_sync_decoder_if;
  // No valid/ready handshake. Every output is either a level or a one-cycle strobe.
  // Consumers must sample on every pclk edge. The decoder cannot stall the byte stream.
  logic [7:0]  d;
  logic [7:0]  y_out;
  logic        y_valid;
  logic        line_valid;
  logic        frame_valid;
  logic        field;
  logic        field_toggle;
  logic        sav_pulse;
  logic        eav_pulse;
  logic [11:0] line_len_last;
  logic        line_len_err;
  logic [15:0] prot_err_cnt;
  logic [2:0]  state_dbg;

  modport master (
    output d,
    input  y_out, y_valid, line_valid, frame_valid, field, field_toggle,
    input  sav_pulse, eav_pulse, line_len_last, line_len_err, prot_err_cnt,
    input  state_dbg
  );

  modport slave (
    input  d,
    output y_out, y_valid, line_valid, frame_valid, field, field_toggle,
    output sav_pulse, eav_pulse, line_len_last, line_len_err, prot_err_cnt,
    output state_dbg
  );
endinterface

// File: rtl/bt656_sync_decoder.sv
// BT.656 timing-reference parser: it decodes FF 00 00 XY codes, qualifies the active line,
// strobes the luma bytes, and tracks line-length and protection-error diagnostics.
`timescale 1ns/1ps
module bt656_sync_decoder #(
  parameter int ACTIVE_BYTES = 1440,
  parameter bit CHECK_PROT   = 1'b1
) (
  input logic                 pclk,
  input logic                 resetn,
  bt656_sync_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_SEARCH = 3'd0,
    S_H1     = 3'd1,
    S_H2     = 3'd2,
    S_XY     = 3'd3,
    S_ACTIVE = 3'd4
  } state_t;

  localparam logic [11:0] ACTIVE_LEN = 12'(ACTIVE_BYTES);
  localparam logic [11:0] CNT_MAX    = 12'hFFF;
  localparam logic [15:0] PROT_MAX   = 16'hFFFF;

  state_t      state_q;
  state_t      state_d;
  logic [11:0] cnt_q;
  logic        pend_q;

  logic        is_ff;
  logic        is_00;
  logic        xy_f;
  logic        xy_v;
  logic        xy_h;
  logic        prot_ok;
  logic        xy_good;
  logic        accept;
  logic        reject;
  logic        act_data;
  logic        act_end;
  logic        luma;

  // XY byte decode. This logic is only used when state_q is S_XY.
  always_comb begin
    is_ff    = (bus.d == 8'hFF);
    is_00    = (bus.d == 8'h00);
    xy_f     = bus.d[6];
    xy_v     = bus.d[5];
    xy_h     = bus.d[4];
    prot_ok  = (bus.d[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
    xy_good  = bus.d[7] && (prot_ok || !CHECK_PROT);
    accept   = (state_q == S_XY) && xy_good;
    reject   = (state_q == S_XY) && !xy_good;
    act_data = (state_q == S_ACTIVE) && !is_ff;
    act_end  = (state_q == S_ACTIVE) && is_ff;
    luma     = act_data && cnt_q[0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH: if (is_ff) state_d = S_H1;
      S_H1: begin
        if (is_00)      state_d = S_H2;
        else if (is_ff) state_d = S_H1;
        else            state_d = S_SEARCH;
      end
      S_H2: begin
        if (is_00)      state_d = S_XY;
        else if (is_ff) state_d = S_H1;
        else            state_d = S_SEARCH;
      end
      S_XY: begin
        if (accept && !xy_h && !xy_v) state_d = S_ACTIVE;
        else                          state_d = S_SEARCH;
      end
      S_ACTIVE: if (is_ff) state_d = S_H1;
      default:  state_d = S_SEARCH;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) state_q <= S_SEARCH;
    else         state_q <= state_d;
  end

  assign bus.state_dbg = state_q;

  // pend_q marks a line that was ended by an FF and still waits for its EAV.
  // Any header break or rejected XY clears pend_q, which discards the measured length.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q             <= '0;
      pend_q            <= 1'b0;
      bus.y_out         <= '0;
      bus.y_valid       <= 1'b0;
      bus.line_valid    <= 1'b0;
      bus.frame_valid   <= 1'b0;
      bus.field         <= 1'b0;
      bus.field_toggle  <= 1'b0;
      bus.sav_pulse     <= 1'b0;
      bus.eav_pulse     <= 1'b0;
      bus.line_len_last <= '0;
      bus.line_len_err  <= 1'b0;
      bus.prot_err_cnt  <= '0;
    end else begin
      bus.y_valid   <= luma;
      bus.sav_pulse <= accept && !xy_h;
      bus.eav_pulse <= accept && xy_h;
      if (luma) bus.y_out <= bus.d;

      if (act_data && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 12'd1;
      if (accept && !xy_h && !xy_v) begin
        cnt_q          <= '0;
        bus.line_valid <= 1'b1;
      end
      if (act_end) bus.line_valid <= 1'b0;

      if (act_end)                                    pend_q <= 1'b1;
      else if ((state_q == S_XY) || (state_d == S_SEARCH)) pend_q <= 1'b0;

      if (accept) begin
        bus.field       <= xy_f;
        bus.frame_valid <= !xy_v;
        if (xy_f != bus.field) bus.field_toggle <= ~bus.field_toggle;
        if (xy_h && pend_q) begin
          bus.line_len_last <= cnt_q;
          bus.line_len_err  <= (cnt_q != ACTIVE_LEN);
        end
      end

      if (reject && (bus.prot_err_cnt != PROT_MAX))
        bus.prot_err_cnt <= bus.prot_err_cnt + 16'd1;
    end
  end

endmodule
